frame_stream_source: RTL and testbench



---
 rtl/frame_stream_pkg.sv | 18 +
 rtl/frame_stream_delay.sv | 45 ++++
 rtl/frame_stream_source.sv | 158 +++++++++++++++
 tb/tb_frame_stream_source.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/frame_stream_pkg.sv
// Shared definitions for the camera pixel pipeline:
// FSM state codes and the default frame geometry.
package frame_stream_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_LEAD = 3'd1;
  localparam state_t ST_ROW  = 3'd2;
  localparam state_t ST_HGAP = 3'd3;
  localparam state_t ST_TAIL = 3'd4;

  localparam int DEF_COLS       = 320;
  localparam int DEF_ROWS       = 240;
  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_H_BLANK    = 16;

endpackage

// File: rtl/frame_stream_delay.sv
// N-stage aligner for the fsync/rsync/data bundle.
// Data advances only with row-valid, so the output holds its last pixel.
module frame_stream_delay
  import frame_stream_pkg::*;
#(
  parameter int N          = 2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  src_fsync,
  input  logic                  src_rsync,
  input  logic [DATA_WIDTH-1:0] src_data,
  output logic                  fsync,
  output logic                  rsync,
  output logic [DATA_WIDTH-1:0] data
);

  logic [N-1:0]          fs;
  logic [N-1:0]          rs;
  logic [DATA_WIDTH-1:0] dt [N];

  // shift sideband every cycle; data only moves with rsync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs <= '0;
      rs <= '0;
      for (int i = 0; i < N; i++) dt[i] <= '0;
    end else begin
      fs[0] <= src_fsync;
      rs[0] <= src_rsync;
      if (src_rsync) dt[0] <= src_data;
      for (int i = 1; i < N; i++) begin
        fs[i] <= fs[i-1];
        rs[i] <= rs[i-1];
        if (rs[i-1]) dt[i] <= dt[i-1];
      end
    end
  end

  assign fsync = fs[N-1];
  assign rsync = rs[N-1];
  assign data  = dt[N-1];

endmodule

// File: rtl/frame_stream_source.sv
// Frame-rate fsync/rsync/pdata transmitter reading a frame RAM.
// FRAME_STREAM_TEST_PATTERN_EN: emit col^row instead of RAM data.
module frame_stream_source
  import frame_stream_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int NO_OF_COLS = DEF_COLS,
  parameter int NO_OF_ROWS = DEF_ROWS,
  parameter int H_BLANK    = DEF_H_BLANK,
  parameter int ADDR_WIDTH = $clog2(NO_OF_COLS*NO_OF_ROWS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  mem_rd,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  fsync,
  output logic                  rsync,
  output logic [DATA_WIDTH-1:0] pdata_out,
  output logic                  busy,
  output logic                  frame_done
);

  localparam int CW = $clog2(NO_OF_COLS + 1);
  localparam int RW = $clog2(NO_OF_ROWS + 1);
  localparam int BW = $clog2(H_BLANK + 1);
  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX =
    ADDR_WIDTH'(NO_OF_COLS*NO_OF_ROWS - 1);

  state_t                state;
  state_t                state_nx;
  logic [CW-1:0]         col;
  logic [RW-1:0]         row;
  logic [BW-1:0]         cnt;
  logic                  accept;
  logic                  blank_end;
  logic                  col_end;
  logic                  row_end;
  logic                  fsync1;
  logic                  rsync1;
  logic                  fall;
  logic [DATA_WIDTH-1:0] data1;

  assign accept    = (state == ST_IDLE) && start && !busy;
  assign blank_end = cnt == BW'(H_BLANK - 1);
  assign col_end   = col == CW'(NO_OF_COLS - 1);
  assign row_end   = row == RW'(NO_OF_ROWS - 1);
  assign fall      = fsync & ~fsync1;

  // frame sequencing: lead blank, rows with gaps, tail blank
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (accept)    state_nx = ST_LEAD;
      ST_LEAD: if (blank_end) state_nx = ST_ROW;
      ST_ROW:  if (col_end)   state_nx = ST_HGAP;
      ST_HGAP: if (blank_end) state_nx = row_end ? ST_TAIL : ST_ROW;
      ST_TAIL: if (blank_end) state_nx = ST_IDLE;
      default:                state_nx = ST_IDLE;
    endcase
  end

  // state, blank counter and raster position
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      col   <= '0;
      row   <= '0;
    end else begin
      state <= state_nx;
      if (state_nx != state)
        cnt <= '0;
      else if (state != ST_IDLE && state != ST_ROW)
        cnt <= cnt + 1'b1;
      if (state == ST_ROW)
        col <= col_end ? '0 : col + 1'b1;
      if (state == ST_HGAP && blank_end && !row_end)
        row <= row + 1'b1;
      else if (state == ST_TAIL && blank_end)
        row <= '0;
    end
  end

  // linear read address, restarted per frame, saturating at the last pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      mem_addr <= '0;
    else if (accept)
      mem_addr <= '0;
    else if (state == ST_ROW && mem_addr != ADDR_MAX)
      mem_addr <= mem_addr + 1'b1;
  end

  // first sideband stage, lines up with RAM read latency
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsync1 <= 1'b0;
      rsync1 <= 1'b0;
    end else begin
      fsync1 <= state != ST_IDLE;
      rsync1 <= state == ST_ROW;
    end
  end

`ifdef FRAME_STREAM_TEST_PATTERN_EN
  logic [DATA_WIDTH-1:0] pat;
  logic [DATA_WIDTH-1:0] pat1;
  logic                  unused_rdata;

  assign pat          = DATA_WIDTH'(col) ^ DATA_WIDTH'(row);
  assign unused_rdata = ^mem_rdata;
  assign mem_rd       = 1'b0;
  assign data1        = pat1;

  // pattern takes the slot the RAM latency would occupy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pat1 <= '0;
    else     pat1 <= pat;
  end
`else
  assign data1 = mem_rdata;

  // read strobe registered so it is high exactly in ROW cycles
  always_ff @(posedge clk or posedge rst) begin
    if (rst) mem_rd <= 1'b0;
    else     mem_rd <= state_nx == ST_ROW;
  end
`endif

  frame_stream_delay #(
    .N          (1),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_align (
    .clk       (clk),
    .rst       (rst),
    .src_fsync (fsync1),
    .src_rsync (rsync1),
    .src_data  (data1),
    .fsync     (fsync),
    .rsync     (rsync),
    .data      (pdata_out)
  );

  // busy spans accept to the fall of the delayed fsync
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= fall;
      if (accept)    busy <= 1'b1;
      else if (fall) busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_frame_stream_source.sv
// Scoreboard bench for frame_stream_source on a small geometry.
// Timing is predicted from frame arithmetic, pixels from a RAM image.
module tb_frame_stream_source;

  localparam int COLS = 4;
  localparam int ROWS = 3;
  localparam int HB   = 2;
  localparam int DW   = 8;
  localparam int AW   = $clog2(COLS*ROWS);
  localparam int L    = HB + ROWS*(COLS+HB) + HB;
  localparam int F    = 2 + L;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          mem_rd;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_rdata = '0;
  logic          fsync;
  logic          rsync;
  logic [DW-1:0] pdata_out;
  logic          busy;
  logic          frame_done;

  logic [DW-1:0] ram [COLS*ROWS];

  int            cyc = 0;
  int            next_ok = 0;
  int            checks = 0;
  int            errors = 0;
  int            done_cnt = 0;
  logic [DW-1:0] last_pix = '0;
  int            acc_q[$];
  logic [DW-1:0] pix_q[$];

  frame_stream_source #(
    .DATA_WIDTH (DW),
    .NO_OF_COLS (COLS),
    .NO_OF_ROWS (ROWS),
    .H_BLANK    (HB),
    .ADDR_WIDTH (AW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .fsync      (fsync),
    .rsync      (rsync),
    .pdata_out  (pdata_out),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial forever #5 clk = ~clk;

  // synchronous RAM; garbage when not read
  always @(posedge clk)
    mem_rdata <= mem_rd ? ram[mem_addr] : DW'($urandom);

  task automatic chk(input string name, input longint act,
                     input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // u = cycles since the frame left IDLE
  function automatic bit in_row(input int u);
    int v;
    v = u - HB;
    if (v < 0 || v >= ROWS*(COLS+HB)) return 1'b0;
    return (v % (COLS+HB)) < COLS;
  endfunction

  function automatic int pix_index(input int u);
    int v;
    v = u - HB;
    return (v / (COLS+HB))*COLS + v % (COLS+HB);
  endfunction

  function automatic logic [DW-1:0] exp_pixel(input int idx);
`ifdef FRAME_STREAM_TEST_PATTERN_EN
    return DW'((idx % COLS) ^ (idx / COLS));
`else
    return ram[idx];
`endif
  endfunction

  task automatic accept_frame(input int edge_no);
    acc_q.push_back(edge_no);
    next_ok = edge_no + F + 1;
    for (int i = 0; i < COLS*ROWS; i++)
      pix_q.push_back(exp_pixel(i));
  endtask

  // drive start for the next edge and predict acceptance
  task automatic tick(input bit s);
    start = s;
    if (!rst && s && (cyc + 1) >= next_ok) accept_frame(cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic flush_model();
    acc_q.delete();
    pix_q.delete();
    next_ok  = 0;
    last_pix = '0;
  endtask

  // monitor: compare every cycle against the frame model
  always @(negedge clk) begin
    if (!rst) begin
      bit            done_exp;
      bit            busy_exp;
      bit            fs_exp;
      bit            rs_exp;
      bit            rd_exp;
      int            a;
      logic [DW-1:0] px;
      done_exp = 0;
      busy_exp = 0;
      fs_exp   = 0;
      rs_exp   = 0;
      rd_exp   = 0;
      a        = 0;
      if (acc_q.size() != 0) begin
        a = acc_q[0];
        if (cyc == a + F) begin
          done_exp = 1;
          void'(acc_q.pop_front());
        end else if (cyc >= a) begin
          busy_exp = 1;
          rd_exp   = (cyc < a + L) && in_row(cyc - a);
          fs_exp   = cyc >= a + 2;
          rs_exp   = fs_exp && in_row(cyc - a - 2);
        end
      end
`ifdef FRAME_STREAM_TEST_PATTERN_EN
      rd_exp = 0;
`endif
      chk("frame_done", frame_done, done_exp);
      chk("busy", busy, busy_exp);
      chk("fsync", fsync, fs_exp);
      chk("rsync", rsync, rs_exp);
      chk("rsync_outside_fsync", rsync & ~fsync, 0);
      chk("mem_rd", mem_rd, rd_exp);
      if (mem_rd && rd_exp)
        chk("mem_addr", mem_addr, pix_index(cyc - a));
      if (frame_done) done_cnt++;
      if (fsync && rsync) begin
        if (pix_q.size() == 0) begin
          chk("pixel_underflow", 1, 0);
        end else begin
          px = pix_q.pop_front();
          chk("pdata", pdata_out, px);
          last_pix = px;
        end
      end else begin
        chk("pdata_hold", pdata_out, last_pix);
      end
    end
  end

  initial begin
    int d0;
    for (int i = 0; i < COLS*ROWS; i++) ram[i] = DW'($urandom);
    repeat (3) tick(0);
    chk("rst_fsync", fsync, 0);
    chk("rst_rsync", rsync, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_pdata", pdata_out, 0);
    chk("rst_addr", mem_addr, 0);
    rst = 1'b0;
    tick(0);

    // single frame from a one-cycle pulse
    d0 = done_cnt;
    tick(1);
    repeat (F + 3) tick(0);
    chk("single_frame", done_cnt - d0, 1);

    // start pulsed mid-frame is dropped
    d0 = done_cnt;
    tick(1);
    repeat (5) tick(0);
    tick(1);
    repeat (F + 3) tick(0);
    chk("midframe_start", done_cnt - d0, 1);

    // start held high for three frame periods
    d0 = done_cnt;
    repeat (3*(F + 1)) tick(1);
    repeat (F + 3) tick(0);
    chk("held_frames", done_cnt - d0, 3);

    // reset while sending row 1 col 2
    tick(1);
    repeat (HB + (COLS + HB) + 2) tick(0);
    chk("pre_rst_fsync", fsync, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_fsync", fsync, 0);
    chk("mid_rst_rsync", rsync, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_done", frame_done, 0);
    flush_model();
    repeat (2) tick(0);
    rst = 1'b0;
    d0 = done_cnt;
    tick(1);
    repeat (F + 3) tick(0);
    chk("post_rst_frame", done_cnt - d0, 1);

    // random start traffic
    repeat (300) tick($urandom_range(0, 7) == 0);
    repeat (F + 4) tick(0);
    chk("pixels_left", pix_q.size(), 0);
    chk("frames_left", acc_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
